// File: rtl/afu_port_reset_pkg.sv
// Shared types and width helper for the AFU per-port reset sequencer.
package afu_port_reset_pkg;

  typedef enum logic [1:0] {
    ST_HOLD     = 2'd0,
    ST_WAIT_REL = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_QUIESCE  = 2'd3
  } t_port_rst_state;

  localparam int unsigned STATE_W = 32'd2;

  // Width of a counter that must be able to hold max_val itself.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 32'd1) ? 32'd1 : $clog2(max_val + 32'd1);
  endfunction

endpackage

// File: rtl/afu_port_reset_fsm.sv
// One AFU port: soft-reset synchronizer, HOLD/WAIT_REL/ACTIVE/QUIESCE FSM, hold counter.
// AFU_PORT_RST_QUIESCE_TIMEOUT_EN adds a QUIESCE timeout with a sticky flag.
module afu_port_reset_fsm
  import afu_port_reset_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 16
`ifdef AFU_PORT_RST_QUIESCE_TIMEOUT_EN
  , parameter int unsigned QUIESCE_TIMEOUT = 1024
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic soft_rst_n,
  input  logic quiesce_ack,
  input  logic grant,
  output logic rel_req,
  output logic quiesce_req,
  output logic port_rst_n,
  output logic port_active
`ifdef AFU_PORT_RST_QUIESCE_TIMEOUT_EN
  , output logic quiesce_timeout
`endif
);

  localparam int unsigned HOLD_W = cnt_width(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 32'd1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(32'd1);

`ifdef AFU_PORT_RST_QUIESCE_TIMEOUT_EN
  localparam int unsigned TMO_W = cnt_width(QUIESCE_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(QUIESCE_TIMEOUT - 32'd1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(32'd1);
  logic [TMO_W-1:0] tmo_cnt_r;
`endif

  logic [SYNC_STAGES-1:0] sync_r;
  logic [HOLD_W-1:0]      hold_cnt_r;
  t_port_rst_state        state_r;
  logic                   synced_s;
  logic                   hold_done_s;

  assign synced_s = sync_r[SYNC_STAGES-1];
  // Exit on the edge the count reaches HOLD_CYCLES so the earliest grant lands HOLD_CYCLES+1 after entry.
  assign hold_done_s = (hold_cnt_r >= HOLD_LAST);
  assign rel_req = (state_r == ST_WAIT_REL);

  // Synchronizer, per-port state machine and its registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r      <= '0;
      state_r     <= ST_HOLD;
      hold_cnt_r  <= '0;
      quiesce_req <= 1'b0;
      port_rst_n  <= 1'b0;
      port_active <= 1'b0;
`ifdef AFU_PORT_RST_QUIESCE_TIMEOUT_EN
      tmo_cnt_r       <= '0;
      quiesce_timeout <= 1'b0;
`endif
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], soft_rst_n};
      if ((state_r == ST_HOLD) && (hold_cnt_r != HOLD_MAX)) begin
        hold_cnt_r <= hold_cnt_r + HOLD_ONE;
      end
      case (state_r)
        ST_HOLD: begin
          if (hold_done_s && synced_s) begin
            state_r <= ST_WAIT_REL;
          end
        end
        ST_WAIT_REL: begin
          if (grant) begin
            state_r     <= ST_ACTIVE;
            port_rst_n  <= 1'b1;
            port_active <= 1'b1;
          end else if (!synced_s) begin
            state_r    <= ST_HOLD;
            hold_cnt_r <= '0;
          end
        end
        ST_ACTIVE: begin
          if (!synced_s) begin
            state_r     <= ST_QUIESCE;
            port_active <= 1'b0;
            quiesce_req <= 1'b1;
`ifdef AFU_PORT_RST_QUIESCE_TIMEOUT_EN
            tmo_cnt_r <= '0;
`endif
          end
        end
        ST_QUIESCE: begin
          // Reset is committed here: a returning soft request does not abort the drain.
          if (quiesce_ack) begin
            state_r     <= ST_HOLD;
            hold_cnt_r  <= '0;
            quiesce_req <= 1'b0;
            port_rst_n  <= 1'b0;
`ifdef AFU_PORT_RST_QUIESCE_TIMEOUT_EN
          end else if (tmo_cnt_r == TMO_LAST) begin
            state_r         <= ST_HOLD;
            hold_cnt_r      <= '0;
            quiesce_req     <= 1'b0;
            port_rst_n      <= 1'b0;
            quiesce_timeout <= 1'b1;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
`endif
          end
        end
        default: begin
          state_r     <= ST_HOLD;
          hold_cnt_r  <= '0;
          quiesce_req <= 1'b0;
          port_rst_n  <= 1'b0;
          port_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/afu_port_reset_seq.sv
// Per-port AFU reset sequencer: one FSM per port plus a shared staggered release arbiter.
// AFU_PORT_RST_QUIESCE_TIMEOUT_EN enables the QUIESCE timeout and the quiesce_timeout port.
module afu_port_reset_seq
  import afu_port_reset_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = 1,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned STAGGER_CYCLES = 4
`ifdef AFU_PORT_RST_QUIESCE_TIMEOUT_EN
  , parameter int unsigned QUIESCE_TIMEOUT = 1024
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] port_soft_rst_n,
  input  logic [NUM_PORTS-1:0] port_quiesce_ack,
  output logic [NUM_PORTS-1:0] port_quiesce_req,
  output logic [NUM_PORTS-1:0] port_rst_n,
  output logic [NUM_PORTS-1:0] port_active
`ifdef AFU_PORT_RST_QUIESCE_TIMEOUT_EN
  , output logic [NUM_PORTS-1:0] quiesce_timeout
`endif
);

  localparam int unsigned GAP_W = cnt_width(STAGGER_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(STAGGER_CYCLES);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(32'd1);
  localparam logic [NUM_PORTS-1:0] PORT_ONE = NUM_PORTS'(32'd1);

  logic [NUM_PORTS-1:0] rel_req_s;
  logic [NUM_PORTS-1:0] grant_s;
  logic [GAP_W-1:0]     gap_cnt_r;
  logic                 gap_free_s;

  // A count of 1 expires on this edge, so a grant is allowed exactly STAGGER_CYCLES after the last.
  assign gap_free_s = (gap_cnt_r <= GAP_ONE);

  // Lowest-index requester wins, isolated as the lowest set bit.
  always_comb begin
    grant_s = '0;
    if (gap_free_s) begin
      grant_s = rel_req_s & (~rel_req_s + PORT_ONE);
    end else begin
      grant_s = '0;
    end
  end

  // Stagger gap counter: reload on each grant, count down to zero and hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt_r <= '0;
    end else if (|grant_s) begin
      gap_cnt_r <= GAP_LOAD;
    end else if (gap_cnt_r != '0) begin
      gap_cnt_r <= gap_cnt_r - GAP_ONE;
    end
  end

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    afu_port_reset_fsm #(
      .SYNC_STAGES (SYNC_STAGES),
      .HOLD_CYCLES (HOLD_CYCLES)
`ifdef AFU_PORT_RST_QUIESCE_TIMEOUT_EN
      , .QUIESCE_TIMEOUT (QUIESCE_TIMEOUT)
`endif
    ) u_fsm (
      .clk         (clk),
      .rst         (rst),
      .soft_rst_n  (port_soft_rst_n[k]),
      .quiesce_ack (port_quiesce_ack[k]),
      .grant       (grant_s[k]),
      .rel_req     (rel_req_s[k]),
      .quiesce_req (port_quiesce_req[k]),
      .port_rst_n  (port_rst_n[k]),
      .port_active (port_active[k])
`ifdef AFU_PORT_RST_QUIESCE_TIMEOUT_EN
      , .quiesce_timeout (quiesce_timeout[k])
`endif
    );
  end

endmodule

// File: tb/tb_afu_port_reset_seq.sv
// Directed self-checking bench for afu_port_reset_seq (4 ports, hold 16, stagger 4).
// With AFU_PORT_RST_QUIESCE_TIMEOUT_EN defined it also exercises the QUIESCE timeout.
module tb_afu_port_reset_seq;

  localparam int unsigned NP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] port_soft_rst_n;
  logic [NP-1:0] port_quiesce_ack;
  logic [NP-1:0] port_quiesce_req;
  logic [NP-1:0] port_rst_n;
  logic [NP-1:0] port_active;
`ifdef AFU_PORT_RST_QUIESCE_TIMEOUT_EN
  logic [NP-1:0] quiesce_timeout;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  afu_port_reset_seq #(
    .NUM_PORTS      (NP),
    .SYNC_STAGES    (2),
    .HOLD_CYCLES    (16),
    .STAGGER_CYCLES (4)
`ifdef AFU_PORT_RST_QUIESCE_TIMEOUT_EN
    , .QUIESCE_TIMEOUT (8)
`endif
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .port_soft_rst_n  (port_soft_rst_n),
    .port_quiesce_ack (port_quiesce_ack),
    .port_quiesce_req (port_quiesce_req),
    .port_rst_n       (port_rst_n),
    .port_active      (port_active)
`ifdef AFU_PORT_RST_QUIESCE_TIMEOUT_EN
    , .quiesce_timeout (quiesce_timeout)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    port_soft_rst_n = 4'hF;
    port_quiesce_ack = 4'h0;
    repeat (3) tick();
    checks++;
    if ({port_quiesce_req, port_rst_n, port_active} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs got req=%b rst_n=%b act=%b want all 0",
               port_quiesce_req, port_rst_n, port_active);
    end
  endtask

  task automatic test_power_on();
    logic [NP-1:0] exp_v;
    rst = 1'b0;
    for (int n = 1; n <= 32; n++) begin
      tick();
      for (int k = 0; k < 4; k++) exp_v[k] = (n >= 17 + 4 * k);
      checks++;
      if (port_rst_n !== exp_v || port_active !== exp_v || port_quiesce_req !== 4'h0) begin
        errors++;
        $display("FAIL power_on cyc %0d got rst_n=%b act=%b req=%b want rst_n=act=%b req=0000",
                 n, port_rst_n, port_active, port_quiesce_req, exp_v);
      end
    end
  endtask

  task automatic test_soft_drain();
    logic [NP-1:0] exp_rst, exp_act, exp_req;
    for (int n = 1; n <= 50; n++) begin
      if (n == 1)  port_soft_rst_n[2] = 1'b0;
      if (n == 14) port_quiesce_ack[2] = 1'b1;
      if (n == 15) port_quiesce_ack[2] = 1'b0;
      if (n == 41) port_soft_rst_n[2] = 1'b1;
      tick();
      exp_rst = 4'hF;
      exp_act = 4'hF;
      exp_req = 4'h0;
      if (n >= 14 && n < 44) exp_rst[2] = 1'b0;
      if (n >= 3 && n < 44)  exp_act[2] = 1'b0;
      if (n >= 3 && n < 14)  exp_req[2] = 1'b1;
      checks++;
      if (port_rst_n !== exp_rst || port_active !== exp_act || port_quiesce_req !== exp_req) begin
        errors++;
        $display("FAIL soft_drain cyc %0d got rst_n=%b act=%b req=%b want %b %b %b",
                 n, port_rst_n, port_active, port_quiesce_req, exp_rst, exp_act, exp_req);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [NP-1:0] exp_rst, exp_act, exp_req;
    for (int n = 1; n <= 30; n++) begin
      if (n == 1) begin
        port_soft_rst_n = 4'b0110;
        port_quiesce_ack = 4'b1001;
      end
      if (n == 5) begin
        port_soft_rst_n = 4'hF;
        port_quiesce_ack = 4'h0;
      end
      tick();
      exp_rst = 4'hF;
      exp_act = 4'hF;
      exp_req = 4'h0;
      if (n >= 4 && n < 21) exp_rst[0] = 1'b0;
      if (n >= 4 && n < 25) exp_rst[3] = 1'b0;
      if (n >= 3 && n < 21) exp_act[0] = 1'b0;
      if (n >= 3 && n < 25) exp_act[3] = 1'b0;
      if (n == 3) exp_req = 4'b1001;
      checks++;
      if (port_rst_n !== exp_rst || port_active !== exp_act || port_quiesce_req !== exp_req) begin
        errors++;
        $display("FAIL simultaneous cyc %0d got rst_n=%b act=%b req=%b want %b %b %b",
                 n, port_rst_n, port_active, port_quiesce_req, exp_rst, exp_act, exp_req);
      end
    end
  endtask

  task automatic test_glitch();
    logic [NP-1:0] exp_rst, exp_act, exp_req;
    for (int n = 1; n <= 45; n++) begin
      if (n == 1) begin
        port_soft_rst_n = 4'b1100;
        port_quiesce_ack = 4'b0011;
      end
      if (n == 5) begin
        port_soft_rst_n = 4'hF;
        port_quiesce_ack = 4'h0;
      end
      if (n == 20) port_soft_rst_n[1] = 1'b0;
      if (n == 24) port_soft_rst_n[1] = 1'b1;
      tick();
      exp_rst = 4'hF;
      exp_act = 4'hF;
      exp_req = 4'h0;
      if (n >= 4 && n < 21) exp_rst[0] = 1'b0;
      if (n >= 4 && n < 39) exp_rst[1] = 1'b0;
      if (n >= 3 && n < 21) exp_act[0] = 1'b0;
      if (n >= 3 && n < 39) exp_act[1] = 1'b0;
      if (n == 3) exp_req = 4'b0011;
      checks++;
      if (port_rst_n !== exp_rst || port_active !== exp_act || port_quiesce_req !== exp_req) begin
        errors++;
        $display("FAIL glitch cyc %0d got rst_n=%b act=%b req=%b want %b %b %b",
                 n, port_rst_n, port_active, port_quiesce_req, exp_rst, exp_act, exp_req);
      end
    end
  endtask

  task automatic test_rst_mid_quiesce();
    logic [NP-1:0] exp_v;
    for (int n = 1; n <= 5; n++) begin
      if (n == 1) port_soft_rst_n[3] = 1'b0;
      if (n == 5) begin
        rst = 1'b1;
        port_soft_rst_n[3] = 1'b1;
      end
      tick();
      if (n == 3 || n == 4) begin
        checks++;
        if (port_quiesce_req !== 4'b1000 || port_rst_n !== 4'hF) begin
          errors++;
          $display("FAIL mid_quiesce cyc %0d got req=%b rst_n=%b want 1000 1111",
                   n, port_quiesce_req, port_rst_n);
        end
      end
    end
    checks++;
    if ({port_quiesce_req, port_rst_n, port_active} !== 12'h000) begin
      errors++;
      $display("FAIL rst_pulse got req=%b rst_n=%b act=%b want all 0",
               port_quiesce_req, port_rst_n, port_active);
    end
    rst = 1'b0;
    for (int n = 1; n <= 32; n++) begin
      tick();
      for (int k = 0; k < 4; k++) exp_v[k] = (n >= 17 + 4 * k);
      checks++;
      if (port_rst_n !== exp_v || port_active !== exp_v) begin
        errors++;
        $display("FAIL repeat_power_on cyc %0d got rst_n=%b act=%b want %b",
                 n, port_rst_n, port_active, exp_v);
      end
    end
  endtask

`ifdef AFU_PORT_RST_QUIESCE_TIMEOUT_EN
  task automatic test_timeout();
    logic [NP-1:0] exp_rst, exp_req, exp_tmo;
    for (int n = 1; n <= 20; n++) begin
      if (n == 1)  port_soft_rst_n[1] = 1'b0;
      if (n == 12) port_soft_rst_n[1] = 1'b1;
      tick();
      exp_rst = 4'hF;
      exp_req = 4'h0;
      exp_tmo = 4'h0;
      if (n >= 11) exp_rst[1] = 1'b0;
      if (n >= 3 && n < 11) exp_req[1] = 1'b1;
      if (n >= 11) exp_tmo[1] = 1'b1;
      checks++;
      if (port_rst_n !== exp_rst || port_quiesce_req !== exp_req || quiesce_timeout !== exp_tmo) begin
        errors++;
        $display("FAIL timeout cyc %0d got rst_n=%b req=%b tmo=%b want %b %b %b",
                 n, port_rst_n, port_quiesce_req, quiesce_timeout, exp_rst, exp_req, exp_tmo);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (quiesce_timeout !== 4'h0) begin
      errors++;
      $display("FAIL timeout_clear got %b want 0000", quiesce_timeout);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_power_on();
`ifndef AFU_PORT_RST_QUIESCE_TIMEOUT_EN
    test_soft_drain();
`endif
    test_simultaneous();
    test_glitch();
    test_rst_mid_quiesce();
`ifdef AFU_PORT_RST_QUIESCE_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
